apb_req_arbiter: RTL

- Shares one APB slave port (PSELx/PENABLE/PADDR/PWRITE/PWDATA in; PREADY/PRDATA/PSLVERR out) between NO_REQ local requesters.
- Round-robin arbitration, then sequences each winning request through APB SETUP/ACCESS phases.
- Returns the completion and read data to the winning requester.
- Sits between on-chip requesters and the APB slave/register-file pair; includes a PREADY timeout watchdog.

---
 rtl/apb_req_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB slave port between NO_REQ requesters, with a PREADY watchdog.
// Zero-wait transfer: accept T, SETUP T+1, ACCESS T+2, response T+3; requesters back up on req_ready.
module apb_req_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NO_REQ     = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic [NO_REQ-1:0]            req_valid,
    input  logic [NO_REQ-1:0]            req_write,
    input  logic [NO_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NO_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NO_REQ-1:0]            req_ready,
    output logic [NO_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_err,
    output logic                         rsp_timeout,
    output logic                         PSELx,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [ADDR_WIDTH-1:0]        PADDR,
    output logic [DATA_WIDTH-1:0]        PWDATA,
    input  logic                         PREADY,
    input  logic [DATA_WIDTH-1:0]        PRDATA,
    input  logic                         PSLVERR
);
    localparam int IDX_W = (NO_REQ > 1) ? $clog2(NO_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NO_REQ - 1);

    logic [1:0]            state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic [NO_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic                  found;
    logic [IDX_W-1:0]      win;
    logic [IDX_W:0]        j;
    logic [IDX_W-1:0]      ptr_next;

    // First pending requester at or above the pointer, wrapping modulo NO_REQ.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        j     = '0;
        for (int k = 0; k < NO_REQ; k++) begin
            j = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            if (j >= (IDX_W + 1)'(NO_REQ)) begin
                j = j - (IDX_W + 1)'(NO_REQ);
            end
            if (!found && req_valid[j[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = j[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!PRESET && state_q == ST_IDLE && found) begin
            req_ready[win] = 1'b1;
        end
    end

    assign ptr_next = (owner_q == IDX_LAST) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        write_d       = write_q;
        rsp_valid_d   = '0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_SETUP;
                    owner_d = win;
                    cnt_d   = '0;
                    addr_d  = req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = req_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                    write_d = req_write[win];
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_d              = ST_IDLE;
                    ptr_d                = ptr_next;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d          = write_q ? '0 : PRDATA;
                    rsp_err_d            = PSLVERR;
                    rsp_timeout_d        = 1'b0;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    // Slave never answered: abort and report instead of hanging the bus.
                    state_d              = ST_IDLE;
                    ptr_d                = ptr_next;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d          = '0;
                    rsp_err_d            = 1'b1;
                    rsp_timeout_d        = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            cnt_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            write_q       <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            write_q       <= write_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign PSELx       = (state_q != ST_IDLE);
    assign PENABLE     = (state_q == ST_ACCESS);
    assign PWRITE      = write_q;
    assign PADDR       = addr_q;
    assign PWDATA      = wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
